mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the in-order pipeline. Sits between execute and write-back.
- Accepts one executed op per handshake and issues at most one dcache read or write for it, with one transaction outstanding.
- Sign- or zero-extends load data and presents a registered result (pc, rdaddr, data) to write-back.
- Non-memory ops pass through with one cycle of latency.

Parameters:
XLEN, 64, datapath and address width
RST_VALID, 1'b0, reset value of out.valid

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
ena  input  1  downstream (write-back) can take out this cycle
get  output  1  stage accepts in this cycle
in  input  ma_in_t  valid, pc[63:0], rdaddr[4:0], load, store, funct3[2:0], addr[63:0], wdata[63:0]
out  output  ma_out_t  valid, pc[63:0], rdaddr[4:0], data[63:0]
dcache_r_rqst  output  1  read request pulse
dcache_r_addr  output  64  read byte address
dcache_r_bits  output  3  read size code, equal to funct3
dcache_r_done  input  1  read complete; dcache_r_data is valid this cycle
dcache_r_data  input  64  read data, right-justified (bit 0 is the byte at the address)
dcache_w_rqst  output  1  write request pulse
dcache_w_addr  output  64  write byte address
dcache_w_bits  output  3  write size code (funct3[1:0], upper bit 0)
dcache_w_data  output  64  write data; dcache uses the low 8<<bits bits
dcache_w_done  input  1  write complete

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, out.valid=RST_VALID.
  - out.pc, out.data and out.rdaddr are all 0.
  - Both rqst outputs are 0; addr, bits and w_data outputs are 0.
- States:
  - IDLE: no access in flight.
  - RD_WAIT: a read is in flight.
  - WR_WAIT: a write is in flight.
- Handshake:
  - get = (state==IDLE) & (~out.valid | ena).
  - A transfer happens when get & in.valid.
  - While out.valid & ~ena, out holds stable.
  - If ena and no completion this cycle, out.valid<=0.
- IDLE, transfer with a non-memory op (load=store=0):
  - Next cycle: out = {1, in.pc, in.rdaddr, in.wdata}.
  - Latency is 1 cycle.
- IDLE, transfer with load=1:
  - Latch pc, rdaddr and funct3.
  - Next cycle: dcache_r_rqst=1 for exactly one cycle; r_addr=in.addr; r_bits=in.funct3; state=RD_WAIT.
- IDLE, transfer with store=1:
  - Next cycle: dcache_w_rqst=1 for one cycle; w_addr, w_bits and w_data come from in; state=WR_WAIT.
- load and store both set: treated as load.
- Address, bits and write data stay stable from the request cycle until done.
- RD_WAIT and dcache_r_done (may coincide with the rqst cycle):
  - Next cycle: out.valid=1, out.data=ext(r_data, funct3), state=IDLE.
- Extension by funct3:
  - 000: sign-extend bits [7:0]
  - 001: sign-extend bits [15:0]
  - 010: sign-extend bits [31:0]
  - 011: all 64 bits
  - 100: zero-extend bits [7:0]
  - 101: zero-extend bits [15:0]
  - 110: zero-extend bits [31:0]
  - 111: treated as 011
- WR_WAIT and dcache_w_done:
  - Next cycle: out.valid=1, out.rdaddr=0, out.data=0, state=IDLE.
  - The store retires with no register write.
- Load with rdaddr=0: the access is still performed; out.rdaddr=0.
- done inputs are ignored in IDLE. A done of the wrong kind is ignored in a WAIT state (r_done in WR_WAIT, w_done in RD_WAIT).
- Reset during a WAIT state:
  - Return to IDLE immediately and drop the transaction.
  - A stale done arriving after reset is ignored.
- The previous out may still be pending (ena=0) when a transaction completes. This cannot happen: get=0 blocks acceptance in that case, so a completion never overwrites an unconsumed out.
- Throughput:
  - 1 op/cycle for non-memory ops while ena=1.
  - A memory op costs 2 cycles plus dcache latency.

Decomposition:
- Shared package (pipeline_pkg):
  - ma_in_t and ma_out_t.
  - Funct3 size constants (LB, LH, LW, LD, LBU, LHU, LWU).
  - Existing opcode constants and RST_PC.
- One combinational sub-module, load_ext (inputs data[63:0] and funct3[2:0], output [63:0]), instantiated once on dcache_r_data.
- The FSM and output register stay in mem_access_stage.

Test Plan:
- Pass-through, ena=1: ops wdata=0x11 (rd=5), then 0x22 (rd=6), on consecutive cycles -> out.valid on the next two cycles with data 0x11/rd 5, then 0x22/rd 6; get stays 1.
- LB with r_data=0x80 at addr 0x1000, done 3 cycles after rqst -> r_rqst is a single-cycle pulse with r_addr 0x1000 and r_bits 0; get=0 during the wait; out.data=0xFFFFFFFFFFFFFF80 one cycle after done. Same for LBU -> 0x80.
- LW with r_data=0xDEADBEEF80000000 -> out.data=0xFFFFFFFF80000000; LWU -> 0x0000000080000000.
- SD addr 0x2000, data 0x0123456789ABCDEF, w_done in the same cycle as rqst -> w_bits=3; out.valid with rdaddr 0 one cycle later.
- Backpressure: ena=0 while out.valid -> get=0 and out holds stable; in.valid op not accepted until ena=1.
- rst=0 during RD_WAIT, then r_done pulses two cycles later -> out.valid stays 0, state IDLE, no rqst reissued.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: memory-stage payloads, load/store size codes,
// opcodes, reset PC and the memory-stage FSM states.
package pipeline_pkg;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rdaddr;
        logic        load;
        logic        store;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
    } ma_in_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rdaddr;
        logic [63:0] data;
    } ma_out_t;

    typedef enum logic [1:0] {
        MA_IDLE    = 2'd0,
        MA_RD_WAIT = 2'd1,
        MA_WR_WAIT = 2'd2
    } ma_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-cache port of the memory-access stage: one read and one write channel,
// each a request pulse with stable address/size held until done.
interface mem_access_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            dcache_r_rqst;
    logic [XLEN-1:0] dcache_r_addr;
    logic [2:0]      dcache_r_bits;
    logic            dcache_r_done;
    logic [63:0]     dcache_r_data;
    logic            dcache_w_rqst;
    logic [XLEN-1:0] dcache_w_addr;
    logic [2:0]      dcache_w_bits;
    logic [63:0]     dcache_w_data;
    logic            dcache_w_done;

    modport master (
        output dcache_r_rqst, dcache_r_addr, dcache_r_bits,
        input  dcache_r_done, dcache_r_data,
        output dcache_w_rqst, dcache_w_addr, dcache_w_bits, dcache_w_data,
        input  dcache_w_done
    );

    modport slave (
        input  dcache_r_rqst, dcache_r_addr, dcache_r_bits,
        output dcache_r_done, dcache_r_data,
        input  dcache_w_rqst, dcache_w_addr, dcache_w_bits, dcache_w_data,
        output dcache_w_done
    );
endinterface

// File: rtl/mem_access_stage_load_ext.sv
// Load data extension: sign- or zero-extends right-justified dcache read data
// according to the load's funct3 size code.
module load_ext
    import pipeline_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  funct3,
    output logic [63:0] ext
);

    always_comb begin
        ext = data;
        case (funct3)
            LB:      ext = {{56{data[7]}},  data[7:0]};
            LH:      ext = {{48{data[15]}}, data[15:0]};
            LW:      ext = {{32{data[31]}}, data[31:0]};
            LBU:     ext = {56'd0, data[7:0]};
            LHU:     ext = {48'd0, data[15:0]};
            LWU:     ext = {32'd0, data[31:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one dcache transaction in flight, registered result to
// write-back; non-memory ops pass through with one cycle of latency.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter logic        RST_VALID = 1'b0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    ena,
    output logic    get,
    input  ma_in_t  in,
    output ma_out_t out,
    mem_access_stage_if.master dcache
);

    ma_state_e       state_q,   state_d;
    ma_out_t         out_q,     out_d;
    logic            r_rqst_q,  r_rqst_d;
    logic [XLEN-1:0] r_addr_q,  r_addr_d;
    logic [2:0]      r_bits_q,  r_bits_d;
    logic            w_rqst_q,  w_rqst_d;
    logic [XLEN-1:0] w_addr_q,  w_addr_d;
    logic [2:0]      w_bits_q,  w_bits_d;
    logic [63:0]     w_data_q,  w_data_d;
    logic [63:0]     pend_pc_q, pend_pc_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic [2:0]      pend_f3_q, pend_f3_d;
    logic [63:0]     load_data;

    load_ext u_load_ext (
        .data   (dcache.dcache_r_data),
        .funct3 (pend_f3_q),
        .ext    (load_data)
    );

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        r_rqst_d  = 1'b0;
        r_addr_d  = r_addr_q;
        r_bits_d  = r_bits_q;
        w_rqst_d  = 1'b0;
        w_addr_d  = w_addr_q;
        w_bits_d  = w_bits_q;
        w_data_d  = w_data_q;
        pend_pc_d = pend_pc_q;
        pend_rd_d = pend_rd_q;
        pend_f3_d = pend_f3_q;

        get = (state_q == MA_IDLE) && (!out_q.valid || ena);

        if (ena) begin
            out_d.valid = 1'b0;
        end

        case (state_q)
            MA_IDLE: begin
                if (get && in.valid) begin
                    // load takes priority when both load and store are flagged
                    if (in.load) begin
                        pend_pc_d = in.pc;
                        pend_rd_d = in.rdaddr;
                        pend_f3_d = in.funct3;
                        r_rqst_d  = 1'b1;
                        r_addr_d  = in.addr;
                        r_bits_d  = in.funct3;
                        state_d   = MA_RD_WAIT;
                    end else if (in.store) begin
                        pend_pc_d = in.pc;
                        w_rqst_d  = 1'b1;
                        w_addr_d  = in.addr;
                        w_bits_d  = {1'b0, in.funct3[1:0]};
                        w_data_d  = in.wdata;
                        state_d   = MA_WR_WAIT;
                    end else begin
                        out_d = '{valid: 1'b1, pc: in.pc, rdaddr: in.rdaddr, data: in.wdata};
                    end
                end
            end
            MA_RD_WAIT: begin
                if (dcache.dcache_r_done) begin
                    out_d   = '{valid: 1'b1, pc: pend_pc_q, rdaddr: pend_rd_q, data: load_data};
                    state_d = MA_IDLE;
                end
            end
            MA_WR_WAIT: begin
                if (dcache.dcache_w_done) begin
                    out_d   = '{valid: 1'b1, pc: pend_pc_q, rdaddr: 5'd0, data: 64'd0};
                    state_d = MA_IDLE;
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= MA_IDLE;
            out_q       <= '0;
            out_q.valid <= RST_VALID;
            r_rqst_q    <= 1'b0;
            r_addr_q    <= '0;
            r_bits_q    <= '0;
            w_rqst_q    <= 1'b0;
            w_addr_q    <= '0;
            w_bits_q    <= '0;
            w_data_q    <= '0;
            pend_pc_q   <= '0;
            pend_rd_q   <= '0;
            pend_f3_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            r_rqst_q    <= r_rqst_d;
            r_addr_q    <= r_addr_d;
            r_bits_q    <= r_bits_d;
            w_rqst_q    <= w_rqst_d;
            w_addr_q    <= w_addr_d;
            w_bits_q    <= w_bits_d;
            w_data_q    <= w_data_d;
            pend_pc_q   <= pend_pc_d;
            pend_rd_q   <= pend_rd_d;
            pend_f3_q   <= pend_f3_d;
        end
    end

    assign out                  = out_q;
    assign dcache.dcache_r_rqst = r_rqst_q;
    assign dcache.dcache_r_addr = r_addr_q;
    assign dcache.dcache_r_bits = r_bits_q;
    assign dcache.dcache_w_rqst = w_rqst_q;
    assign dcache.dcache_w_addr = w_addr_q;
    assign dcache.dcache_w_bits = w_bits_q;
    assign dcache.dcache_w_data = w_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expected results.
module tb_mem_access_stage;
    import pipeline_pkg::*;

    logic    clk;
    logic    rst;
    logic    ena;
    logic    get;
    ma_in_t  in_s;
    ma_out_t out_s;

    mem_access_stage_if dc_if ();

    mem_access_stage #(.XLEN(64), .RST_VALID(1'b0)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .get    (get),
        .in     (in_s),
        .out    (out_s),
        .dcache (dc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference extension from width arithmetic rather than a per-code table.
    function automatic logic [63:0] m_ext(input logic [63:0] d, input logic [2:0] f);
        int unsigned w;
        logic [63:0] mask;
        logic [63:0] r;
        if (f[1:0] == 2'd3) return d;
        w    = 8 << f[1:0];
        mask = (64'd1 << w) - 64'd1;
        r    = d & mask;
        if (!f[2] && d[w-1]) r = r | ~mask;
        return r;
    endfunction

    bit          started = 0;
    bit          m_pend, m_is_load, m_r_rqst, m_w_rqst, m_ov;
    logic [63:0] m_pc, m_raddr, m_waddr, m_wdata, m_opc, m_odata;
    logic [4:0]  m_rd, m_ord;
    logic [2:0]  m_f3, m_rbits, m_wbits;

    always @(posedge clk) begin : model
        bit acc;
        if (!rst) begin
            started = 1;
            m_pend = 0; m_is_load = 0; m_r_rqst = 0; m_w_rqst = 0; m_ov = 0;
            m_pc = '0; m_raddr = '0; m_waddr = '0; m_wdata = '0; m_opc = '0; m_odata = '0;
            m_rd = '0; m_ord = '0; m_f3 = '0; m_rbits = '0; m_wbits = '0;
        end else begin
            acc = !m_pend && (!m_ov || ena) && in_s.valid;
            m_r_rqst = 0;
            m_w_rqst = 0;
            if (ena) m_ov = 0;
            if (m_pend && m_is_load && dc_if.dcache_r_done) begin
                m_ov = 1; m_opc = m_pc; m_ord = m_rd;
                m_odata = m_ext(dc_if.dcache_r_data, m_f3); m_pend = 0;
            end else if (m_pend && !m_is_load && dc_if.dcache_w_done) begin
                m_ov = 1; m_opc = m_pc; m_ord = 0; m_odata = 0; m_pend = 0;
            end else if (acc) begin
                if (in_s.load) begin
                    m_pend = 1; m_is_load = 1; m_pc = in_s.pc; m_rd = in_s.rdaddr; m_f3 = in_s.funct3;
                    m_r_rqst = 1; m_raddr = in_s.addr; m_rbits = in_s.funct3;
                end else if (in_s.store) begin
                    m_pend = 1; m_is_load = 0; m_pc = in_s.pc;
                    m_w_rqst = 1; m_waddr = in_s.addr; m_wbits = {1'b0, in_s.funct3[1:0]};
                    m_wdata = in_s.wdata;
                end else begin
                    m_ov = 1; m_opc = in_s.pc; m_ord = in_s.rdaddr; m_odata = in_s.wdata;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            chk("m_get", {63'd0, get}, {63'd0, !m_pend && (!m_ov || ena)});
            chk("m_out_valid", {63'd0, out_s.valid}, {63'd0, m_ov});
            if (m_ov) begin
                chk("m_out_pc", out_s.pc, m_opc);
                chk("m_out_rd", {59'd0, out_s.rdaddr}, {59'd0, m_ord});
                chk("m_out_data", out_s.data, m_odata);
            end
            chk("m_r_rqst", {63'd0, dc_if.dcache_r_rqst}, {63'd0, m_r_rqst});
            chk("m_w_rqst", {63'd0, dc_if.dcache_w_rqst}, {63'd0, m_w_rqst});
            if (m_pend && m_is_load) begin
                chk("m_r_addr", dc_if.dcache_r_addr, m_raddr);
                chk("m_r_bits", {61'd0, dc_if.dcache_r_bits}, {61'd0, m_rbits});
            end
            if (m_pend && !m_is_load) begin
                chk("m_w_addr", dc_if.dcache_w_addr, m_waddr);
                chk("m_w_bits", {61'd0, dc_if.dcache_w_bits}, {61'd0, m_wbits});
                chk("m_w_data", dc_if.dcache_w_data, m_wdata);
            end
        end
    end

    logic [63:0] pc_n = 64'h100;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [63:0] addr, input logic [63:0] wd);
        in_s        = '0;
        in_s.valid  = 1'b1;
        in_s.pc     = pc_n;
        in_s.load   = ld;
        in_s.store  = st;
        in_s.funct3 = f3;
        in_s.rdaddr = rd;
        in_s.addr   = addr;
        in_s.wdata  = wd;
        pc_n        = pc_n + 64'd4;
    endtask

    task automatic do_load(input string nm, input bit both, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] addr, input logic [63:0] rdata, input int delay,
                           input bit wrong_done, input logic [63:0] exp);
        logic [63:0] pc_op;
        pc_op = pc_n;
        set_op(1'b1, both, f3, rd, addr, 64'hFEED);
        tick();
        in_s = '0;
        chk({nm, "_rqst"}, {63'd0, dc_if.dcache_r_rqst}, 64'd1);
        chk({nm, "_addr"}, dc_if.dcache_r_addr, addr);
        chk({nm, "_bits"}, {61'd0, dc_if.dcache_r_bits}, {61'd0, f3});
        chk({nm, "_get_wait"}, {63'd0, get}, 64'd0);
        dc_if.dcache_w_done = wrong_done;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 0) chk({nm, "_rqst_pulse"}, {63'd0, dc_if.dcache_r_rqst}, 64'd0);
        end
        dc_if.dcache_w_done = 1'b0;
        dc_if.dcache_r_data = rdata;
        dc_if.dcache_r_done = 1'b1;
        tick();
        dc_if.dcache_r_done = 1'b0;
        chk({nm, "_valid"}, {63'd0, out_s.valid}, 64'd1);
        chk({nm, "_data"}, out_s.data, exp);
        chk({nm, "_rd"}, {59'd0, out_s.rdaddr}, {59'd0, rd});
        chk({nm, "_pc"}, out_s.pc, pc_op);
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wd, input int delay, input logic [2:0] exp_bits);
        set_op(1'b0, 1'b1, f3, 5'd9, addr, wd);
        tick();
        in_s = '0;
        chk({nm, "_wrqst"}, {63'd0, dc_if.dcache_w_rqst}, 64'd1);
        chk({nm, "_waddr"}, dc_if.dcache_w_addr, addr);
        chk({nm, "_wbits"}, {61'd0, dc_if.dcache_w_bits}, {61'd0, exp_bits});
        chk({nm, "_wdata"}, dc_if.dcache_w_data, wd);
        dc_if.dcache_r_done = (delay > 0);
        repeat (delay) tick();
        dc_if.dcache_r_done = 1'b0;
        dc_if.dcache_w_done = 1'b1;
        tick();
        dc_if.dcache_w_done = 1'b0;
        chk({nm, "_valid"}, {63'd0, out_s.valid}, 64'd1);
        chk({nm, "_rd0"}, {59'd0, out_s.rdaddr}, 64'd0);
        chk({nm, "_data0"}, out_s.data, 64'd0);
    endtask

    initial begin
        rst  = 1'b0;
        ena  = 1'b1;
        in_s = '0;
        dc_if.dcache_r_done = 1'b0;
        dc_if.dcache_r_data = '0;
        dc_if.dcache_w_done = 1'b0;
        tick();
        tick();
        chk("rst_out", {out_s.valid, out_s.pc[62:0]}, 64'd0);
        chk("rst_out_data", out_s.data, 64'd0);
        chk("rst_out_rd", {59'd0, out_s.rdaddr}, 64'd0);
        chk("rst_rqst", {62'd0, dc_if.dcache_r_rqst, dc_if.dcache_w_rqst}, 64'd0);
        chk("rst_addr", dc_if.dcache_r_addr | dc_if.dcache_w_addr, 64'd0);
        chk("rst_bits_wdata", dc_if.dcache_w_data | {58'd0, dc_if.dcache_r_bits, dc_if.dcache_w_bits}, 64'd0);
        rst = 1'b1;
        tick();

        // pass-through back to back
        set_op(1'b0, 1'b0, 3'd0, 5'd5, 64'h0, 64'h11);
        tick();
        chk("pt1_data", out_s.data, 64'h11);
        chk("pt1_rd", {59'd0, out_s.rdaddr}, 64'd5);
        set_op(1'b0, 1'b0, 3'd0, 5'd6, 64'h0, 64'h22);
        chk("pt_get", {63'd0, get}, 64'd1);
        tick();
        chk("pt2_data", out_s.data, 64'h22);
        chk("pt2_rd", {59'd0, out_s.rdaddr}, 64'd6);
        in_s = '0;
        tick();
        chk("pt_drain", {63'd0, out_s.valid}, 64'd0);

        do_load("lb",   1'b0, LB,  5'd7,  64'h1000, 64'h80, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu",  1'b0, LBU, 5'd7,  64'h1000, 64'h80, 3, 1'b0, 64'h0000_0000_0000_0080);
        do_load("lw",   1'b0, LW,  5'd8,  64'h1008, 64'hDEAD_BEEF_8000_0000, 1, 1'b0, 64'hFFFF_FFFF_8000_0000);
        do_load("lwu",  1'b0, LWU, 5'd8,  64'h1008, 64'hDEAD_BEEF_8000_0000, 0, 1'b0, 64'h0000_0000_8000_0000);
        do_load("lh",   1'b0, LH,  5'd10, 64'h1010, 64'h1234_8001, 2, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lhu",  1'b0, LHU, 5'd11, 64'h1012, 64'hFFFF_7FFF, 0, 1'b0, 64'h0000_0000_0000_7FFF);
        do_load("ld",   1'b0, LD,  5'd12, 64'h1018, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 64'h0123_4567_89AB_CDEF);
        do_load("f3_7", 1'b0, 3'b111, 5'd13, 64'h1020, 64'h8000_0000_0000_0001, 0, 1'b0, 64'h8000_0000_0000_0001);
        do_load("ldst", 1'b1, LW,  5'd0,  64'h1028, 64'h7FFF_FFFF, 1, 1'b0, 64'h0000_0000_7FFF_FFFF);

        do_store("sd", 3'd3, 64'h2000, 64'h0123_4567_89AB_CDEF, 0, 3'd3);
        do_store("sb", 3'd4, 64'h2001, 64'h55, 2, 3'd0);

        // backpressure: out held, next op waits for ena
        set_op(1'b0, 1'b0, 3'd0, 5'd9, 64'h0, 64'hAA);
        tick();
        ena = 1'b0;
        set_op(1'b0, 1'b0, 3'd0, 5'd10, 64'h0, 64'hBB);
        #1;
        chk("bp_get0", {63'd0, get}, 64'd0);
        tick();
        chk("bp_hold1", out_s.data, 64'hAA);
        tick();
        chk("bp_hold2", {59'd0, out_s.rdaddr}, 64'd9);
        ena = 1'b1;
        #1;
        chk("bp_get1", {63'd0, get}, 64'd1);
        tick();
        chk("bp_next", out_s.data, 64'hBB);
        in_s = '0;
        tick();

        // reset while a read is in flight; late done must be ignored
        set_op(1'b1, 1'b0, LD, 5'd14, 64'h3000, 64'h0);
        tick();
        in_s = '0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        dc_if.dcache_r_data = 64'h1234;
        dc_if.dcache_r_done = 1'b1;
        tick();
        dc_if.dcache_r_done = 1'b0;
        tick();
        chk("rstw_valid", {63'd0, out_s.valid}, 64'd0);
        chk("rstw_rqst", {63'd0, dc_if.dcache_r_rqst}, 64'd0);
        chk("rstw_get", {63'd0, get}, 64'd1);

        do_load("post_rst", 1'b0, LB, 5'd15, 64'h3001, 64'h7F, 1, 1'b0, 64'h7F);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
